// File: rtl/phase_err_det.sv
// Phase-error detector: measures clk cycles between reference and feedback rising edges.
// Emits a saturated signed error sample with a valid strobe, and flags window timeouts or cycle slips.
module phase_err_det #(
    parameter int WIDTH      = 13,
    parameter int CNT_W      = 16,
    parameter int MAX_CNT    = 4095,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ref_in,
    input  logic                    fb_in,
    output logic signed [WIDTH-1:0] err_out,
    output logic                    err_valid,
    output logic                    slip
);

    // state    | meaning
    // IDLE     | no window open, waiting for the first rising edge
    // REF_LEAD | ref rose first, counting until fb rises (positive error)
    // FB_LEAD  | fb rose first, counting until ref rises (negative error)
    typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} state_t;

    localparam int MW   = CNT_W + GAIN_SHIFT;
    localparam int MAXV = 2**(WIDTH-1) - 1;
    localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(MAXV);
    localparam logic [WIDTH-1:0] MAX_NEG = WIDTH'(-MAXV);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ref_s1, ref_s2, ref_d;
    logic             fb_s1, fb_s2, fb_d;
    logic             ref_rise, fb_rise;
    logic [MW-1:0]    mag;
    logic [WIDTH-1:0] pos_err, neg_err;
    logic             timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_s1 <= 1'b0;
            ref_s2 <= 1'b0;
            ref_d  <= 1'b0;
            fb_s1  <= 1'b0;
            fb_s2  <= 1'b0;
            fb_d   <= 1'b0;
        end else begin
            ref_s1 <= ref_in;
            ref_s2 <= ref_s1;
            ref_d  <= ref_s2;
            fb_s1  <= fb_in;
            fb_s2  <= fb_s1;
            fb_d   <= fb_s2;
        end
    end

    assign ref_rise = ref_s2 & ~ref_d;
    assign fb_rise  = fb_s2 & ~fb_d;

    // Negation of a clamped magnitude keeps the output range symmetric (never -2^(WIDTH-1)).
    always_comb begin
        mag     = MW'(cnt) << GAIN_SHIFT;
        pos_err = (mag > MW'(MAXV)) ? MAX_POS : mag[WIDTH-1:0];
        neg_err = -pos_err;
        timeout = (cnt == CNT_W'(MAX_CNT));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            err_out   <= '0;
            err_valid <= 1'b0;
            slip      <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            slip      <= 1'b0;
            case (state)
                IDLE: begin
                    if (ref_rise && fb_rise) begin
                        err_out   <= '0;
                        err_valid <= 1'b1;
                    end else if (ref_rise) begin
                        state <= REF_LEAD;
                        cnt   <= CNT_W'(1);
                    end else if (fb_rise) begin
                        state <= FB_LEAD;
                        cnt   <= CNT_W'(1);
                    end
                end
                REF_LEAD: begin
                    if (fb_rise) begin
                        err_out   <= pos_err;
                        err_valid <= 1'b1;
                        // A coincident ref edge immediately opens the next window.
                        if (ref_rise) begin
                            cnt <= CNT_W'(1);
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else if (ref_rise) begin
                        err_out   <= MAX_POS;
                        err_valid <= 1'b1;
                        slip      <= 1'b1;
                        cnt       <= CNT_W'(1);
                    end else if (timeout) begin
                        err_out   <= MAX_POS;
                        err_valid <= 1'b1;
                        slip      <= 1'b1;
                        state     <= IDLE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FB_LEAD: begin
                    if (ref_rise) begin
                        err_out   <= neg_err;
                        err_valid <= 1'b1;
                        if (fb_rise) begin
                            cnt <= CNT_W'(1);
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else if (fb_rise) begin
                        err_out   <= MAX_NEG;
                        err_valid <= 1'b1;
                        slip      <= 1'b1;
                        cnt       <= CNT_W'(1);
                    end else if (timeout) begin
                        err_out   <= MAX_NEG;
                        err_valid <= 1'b1;
                        slip      <= 1'b1;
                        state     <= IDLE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_err_det.sv
// Directed bench for phase_err_det: a unity-gain instance and a GAIN_SHIFT=6 instance share the same inputs.
module tb_phase_err_det;

    logic clk, rst_n, ref_in, fb_in;
    logic signed [12:0] err_out, err6;
    logic err_valid, slip, valid6, slip6;

    int compared   = 0;
    int mismatched = 0;
    int vcnt       = 0;
    int scnt       = 0;

    phase_err_det #(.WIDTH(13), .CNT_W(16), .MAX_CNT(4095), .GAIN_SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .ref_in(ref_in), .fb_in(fb_in),
        .err_out(err_out), .err_valid(err_valid), .slip(slip));

    phase_err_det #(.WIDTH(13), .CNT_W(16), .MAX_CNT(4095), .GAIN_SHIFT(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .ref_in(ref_in), .fb_in(fb_in),
        .err_out(err6), .err_valid(valid6), .slip(slip6));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and sample 1 ns later; also tallies strobes of the unity-gain instance.
    task automatic tick();
        @(posedge clk);
        #1;
        if (err_valid === 1'b1) vcnt++;
        if (slip === 1'b1) scnt++;
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (err_valid !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ref_in = i[0];
            fb_in  = ~i[0];
            tick();
            compared++;
            if (err_out !== 13'sd0 || err_valid !== 1'b0 || slip !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_hold cyc %0d: err=%0d valid=%b slip=%b, want 0/0/0", i, err_out, err_valid, slip);
            end
            compared++;
            if (err6 !== 13'sd0 || valid6 !== 1'b0 || slip6 !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_hold6 cyc %0d: err=%0d valid=%b slip=%b, want 0/0/0", i, err6, valid6, slip6);
            end
        end
        ref_in = 1'b0;
        fb_in  = 1'b0;
        tick();
        rst_n = 1'b1;
        vcnt = 0;
        repeat (10) tick();
        compared++;
        if (vcnt !== 0) begin
            mismatched++;
            $display("FAIL reset_release: valid pulses %0d, want 0", vcnt);
        end
    endtask

    task automatic test_fb_lags();
        int n, v0;
        for (int p = 0; p < 3; p++) begin
            v0 = vcnt;
            ref_in = 1'b1;
            repeat (37) tick();
            compared++;
            if (vcnt !== v0) begin
                mismatched++;
                $display("FAIL lag_early_valid p%0d: pulses %0d, want 0", p, vcnt - v0);
            end
            fb_in = 1'b1;
            wait_valid(10, n);
            compared++;
            if (n !== 3) begin
                mismatched++;
                $display("FAIL lag_latency p%0d: %0d edges, want 3", p, n);
            end
            compared++;
            if (err_out !== 13'sd37 || slip !== 1'b0) begin
                mismatched++;
                $display("FAIL lag_value p%0d: err=%0d slip=%b, want 37/0", p, err_out, slip);
            end
            compared++;
            if (err6 !== 13'sd2368 || valid6 !== 1'b1) begin
                mismatched++;
                $display("FAIL lag_gain6 p%0d: err=%0d valid=%b, want 2368/1", p, err6, valid6);
            end
            tick();
            compared++;
            if (err_valid !== 1'b0 || err_out !== 13'sd37) begin
                mismatched++;
                $display("FAIL lag_hold p%0d: valid=%b err=%0d, want 0/37", p, err_valid, err_out);
            end
            ref_in = 1'b0;
            fb_in  = 1'b0;
            repeat (200 - 37 - 4) tick();
            compared++;
            if (vcnt !== v0 + 1) begin
                mismatched++;
                $display("FAIL lag_pulses p%0d: %0d pulses, want 1", p, vcnt - v0);
            end
        end
    endtask

    task automatic test_fb_leads();
        int n;
        fb_in = 1'b1;
        repeat (100) tick();
        ref_in = 1'b1;
        wait_valid(10, n);
        compared++;
        if (n !== 3 || err_out !== -13'sd100) begin
            mismatched++;
            $display("FAIL lead_value: edges=%0d err=%0d, want 3/-100", n, err_out);
        end
        compared++;
        if (err6 !== -13'sd4095 || slip6 !== 1'b0) begin
            mismatched++;
            $display("FAIL lead_sat6: err=%0d slip=%b, want -4095/0", err6, slip6);
        end
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_simultaneous();
        int n;
        ref_in = 1'b1;
        fb_in  = 1'b1;
        wait_valid(10, n);
        compared++;
        if (n !== 3 || err_out !== 13'sd0 || slip !== 1'b0) begin
            mismatched++;
            $display("FAIL simul_value: edges=%0d err=%0d slip=%b, want 3/0/0", n, err_out, slip);
        end
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (6) tick();
        ref_in = 1'b1;
        repeat (5) tick();
        fb_in = 1'b1;
        wait_valid(10, n);
        compared++;
        if (n !== 3 || err_out !== 13'sd5) begin
            mismatched++;
            $display("FAIL simul_idle_after: edges=%0d err=%0d, want 3/5", n, err_out);
        end
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_timeout();
        int n;
        ref_in = 1'b1;
        tick();
        ref_in = 1'b0;
        wait_valid(5000, n);
        compared++;
        if (n !== 4097) begin
            mismatched++;
            $display("FAIL timeout_latency: %0d edges after drive, want 4098", n + 1);
        end
        compared++;
        if (err_out !== 13'sd4095 || slip !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_value: err=%0d slip=%b, want 4095/1", err_out, slip);
        end
        repeat (4) tick();
        // Two ref rises 50 apart: second one reports a slip and reopens the window.
        ref_in = 1'b1;
        repeat (5) tick();
        ref_in = 1'b0;
        repeat (45) tick();
        ref_in = 1'b1;
        wait_valid(10, n);
        compared++;
        if (n !== 3 || err_out !== 13'sd4095 || slip !== 1'b1) begin
            mismatched++;
            $display("FAIL slip_value: edges=%0d err=%0d slip=%b, want 3/4095/1", n, err_out, slip);
        end
        repeat (5) tick();
        ref_in = 1'b0;
        repeat (12) tick();
        fb_in = 1'b1;
        wait_valid(10, n);
        compared++;
        if (n !== 3 || err_out !== 13'sd20 || slip !== 1'b0) begin
            mismatched++;
            $display("FAIL slip_recover: edges=%0d err=%0d slip=%b, want 3/20/0", n, err_out, slip);
        end
        compared++;
        if (err6 !== 13'sd1280) begin
            mismatched++;
            $display("FAIL slip_recover6: err=%0d, want 1280", err6);
        end
        fb_in = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset_mid();
        int n, v0;
        ref_in = 1'b1;
        repeat (12) tick();
        ref_in = 1'b0;
        rst_n  = 1'b0;
        tick();
        rst_n = 1'b1;
        v0 = vcnt;
        compared++;
        if (err_out !== 13'sd0 || err_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_clear: err=%0d valid=%b, want 0/0", err_out, err_valid);
        end
        fb_in = 1'b1;
        repeat (30) tick();
        compared++;
        if (vcnt !== v0 || err_out !== 13'sd0) begin
            mismatched++;
            $display("FAIL midrst_no_sample: pulses=%0d err=%0d, want 0/0", vcnt - v0, err_out);
        end
        ref_in = 1'b1;
        wait_valid(10, n);
        compared++;
        if (n !== 3 || err_out !== -13'sd30 || err6 !== -13'sd1920) begin
            mismatched++;
            $display("FAIL midrst_fb_lead: edges=%0d err=%0d err6=%0d, want 3/-30/-1920", n, err_out, err6);
        end
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_back_to_back();
        int n;
        ref_in = 1'b1;
        repeat (4) tick();
        ref_in = 1'b0;
        repeat (6) tick();
        ref_in = 1'b1;
        fb_in  = 1'b1;
        wait_valid(10, n);
        compared++;
        if (n !== 3 || err_out !== 13'sd10 || slip !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_first: edges=%0d err=%0d slip=%b, want 3/10/0", n, err_out, slip);
        end
        repeat (2) tick();
        fb_in = 1'b0;
        repeat (2) tick();
        fb_in = 1'b1;
        wait_valid(10, n);
        compared++;
        if (n !== 3 || err_out !== 13'sd7 || slip !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_second: edges=%0d err=%0d slip=%b, want 3/7/0", n, err_out, slip);
        end
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        test_reset();
        test_fb_lags();
        test_fb_leads();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
